// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, baud divider helpers and command byte
// constants for the UART command receiver.
// Build option: define UART_RX_PARITY_EN for 8E1 framing (default is 8N1).
package uart_pkg;

  // Receiver FSM states; RX_PARITY is only reachable in the 8E1 build.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Uppercase command bytes; lowercase is the same value with bit 5 set.
  localparam logic [7:0] CMD_WORK     = 8'h57;  // 'W'
  localparam logic [7:0] CMD_STOP     = 8'h53;  // 'S'
  localparam logic [7:0] CMD_ENC      = 8'h45;  // 'E'
  localparam logic [7:0] CMD_DEC      = 8'h44;  // 'D'
  localparam logic [7:0] CMD_CLR      = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CASE_BIT = 8'h20;

  // Clock cycles per bit period.
  function automatic int calc_baud_div(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  // Clock cycles per half bit period, used to centre on the start bit.
  function automatic int calc_half_div(input int clk_freq, input int bps);
    return calc_baud_div(clk_freq, bps) / 2;
  endfunction

  // Fold a letter to lowercase so 'W' and 'w' compare equal.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return b | CMD_CASE_BIT;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if: serial input plus received-byte, pulse and control
// outputs of the UART command receiver. The receiver uses the slave view,
// the driver of the serial line and consumer of the outputs the master view.
interface uart_cmd_rx_if;
  import uart_pkg::*;

  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_err;
  logic       work;
  logic       enc;
  logic       clr;

  modport slave (
    input  uart_rxd,
    output rx_data, rx_valid, frame_err, cmd_err, work, enc, clr
  );

  modport master (
    output uart_rxd,
    input  rx_data, rx_valid, frame_err, cmd_err, work, enc, clr
  );
endinterface

// File: rtl/uart_rx_phy.sv
// uart_rx_phy: 2-flop synchroniser, baud counter, frame FSM and shift
// register. byte_valid_o / frame_err_o are single-cycle strobes raised in
// the cycle the stop bit is sampled; byte_o is stable at that point.
// Build option: UART_RX_PARITY_EN adds an even-parity bit (8E1).
module uart_rx_phy #(
  parameter int BAUD_DIV = 434,
  parameter int HALF_DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] S_IDLE   = RX_IDLE;
  localparam logic [2:0] S_START  = RX_START;
  localparam logic [2:0] S_DATA   = RX_DATA;
  localparam logic [2:0] S_STOP   = RX_STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = RX_PARITY;
`endif

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             rxd_s;
  logic             frame_ok_s;
  logic             byte_valid_s;
  logic             frame_err_s;

  assign rxd_s = sync2_q;

`ifdef UART_RX_PARITY_EN
  // Good frame needs a high stop bit and even parity over data+parity.
  assign frame_ok_s = rxd_s & ~(^{shift_q, par_q});
`else
  // Good frame needs a high stop bit.
  assign frame_ok_s = rxd_s;
`endif

  // Next-state logic: synchroniser shift, baud counting and frame sequencing.
  always_comb begin
    sync1_d      = rxd_i;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    bit_d        = bit_q;
    shift_d      = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
`endif
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!rxd_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = CNT_ZERO;
          bit_d = 3'd0;
          // A start bit that is high again by mid-bit was a glitch.
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = CNT_ZERO;
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = CNT_ZERO;
          par_d   = rxd_s;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          // Return to IDLE at once so a following start bit is not missed.
          cnt_d   = CNT_ZERO;
          state_d = S_IDLE;
          if (frame_ok_s) begin
            byte_valid_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers; the synchroniser resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_s;
  assign frame_err_o  = frame_err_s;

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver front end plus ASCII command decoder that
// drives the work/enc levels and the clr pulse. All outputs are registered
// and change one cycle after the stop bit is sampled.
// Build option: UART_RX_PARITY_EN selects 8E1 framing in the receiver.
module uart_cmd_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_rx_if.slave bus
);
  import uart_pkg::*;

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, UART_BPS);
  localparam int HALF_DIV = calc_half_div(CLK_FREQ, UART_BPS);

  localparam logic [7:0] KEY_WORK = CMD_WORK | CMD_CASE_BIT;
  localparam logic [7:0] KEY_STOP = CMD_STOP | CMD_CASE_BIT;
  localparam logic [7:0] KEY_ENC  = CMD_ENC  | CMD_CASE_BIT;
  localparam logic [7:0] KEY_DEC  = CMD_DEC  | CMD_CASE_BIT;
  localparam logic [7:0] KEY_CLR  = CMD_CLR  | CMD_CASE_BIT;

  logic [7:0] phy_byte_s;
  logic       phy_valid_s;
  logic       phy_ferr_s;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       cmd_err_q, cmd_err_d;
  logic       work_q, work_d;
  logic       enc_q, enc_d;
  logic       clr_q, clr_d;

  uart_rx_phy #(
    .BAUD_DIV (BAUD_DIV),
    .HALF_DIV (HALF_DIV)
  ) u_phy (
    .clk          (clk),
    .rst          (rst),
    .rxd_i        (bus.uart_rxd),
    .byte_o       (phy_byte_s),
    .byte_valid_o (phy_valid_s),
    .frame_err_o  (phy_ferr_s)
  );

  // Command decode: a good byte updates rx_data and may change work/enc or
  // request a clear; a bad frame only raises frame_err.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = phy_ferr_s;
    cmd_err_d   = 1'b0;
    work_d      = work_q;
    enc_d       = enc_q;
    clr_d       = 1'b0;
    if (phy_valid_s) begin
      rx_data_d  = phy_byte_s;
      rx_valid_d = 1'b1;
      case (fold_case(phy_byte_s))
        KEY_WORK: work_d    = 1'b1;
        KEY_STOP: work_d    = 1'b0;
        KEY_ENC:  enc_d     = 1'b1;
        KEY_DEC:  enc_d     = 1'b0;
        KEY_CLR:  clr_d     = 1'b1;
        default:  cmd_err_d = 1'b1;
      endcase
    end else begin
      rx_valid_d = 1'b0;
    end
  end

  // Output registers; enc powers up in encrypt mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      work_q      <= 1'b0;
      enc_q       <= 1'b1;
      clr_q       <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      cmd_err_q   <= cmd_err_d;
      work_q      <= work_d;
      enc_q       <= enc_d;
      clr_q       <= clr_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.work      = work_q;
  assign bus.enc       = enc_q;
  assign bus.clr       = clr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: table-driven directed frames, hand-written corner-case
// sequences and random frames checked against a byte-level command model.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 10_000_000;
  localparam int UART_BPS = 250_000;
  localparam int BIT      = CLK_FREQ / UART_BPS;  // 40 cycles per bit
  localparam int HALF     = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * BIT;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         ev;
    logic [7:0] ed;
    int         ec;
    int         ecl;
    int         ef;
    logic       ew;
    logic       ee;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_cmd_rx_if bus ();

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters and exclusivity monitor, sampled on the falling edge.
  int n_valid = 0, n_ferr = 0, n_cerr = 0, n_clr = 0, n_excl = 0;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) n_valid <= n_valid + 1;
    if (bus.frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (bus.cmd_err === 1'b1) n_cerr <= n_cerr + 1;
    if (bus.clr === 1'b1) n_clr <= n_clr + 1;
    if ((bus.frame_err === 1'b1) && (bus.rx_valid || bus.cmd_err || bus.clr))
      n_excl <= n_excl + 1;
    if ((bus.cmd_err === 1'b1 || bus.clr === 1'b1) && bus.rx_valid !== 1'b1)
      n_excl <= n_excl + 1;
  end

  int s_valid, s_ferr, s_cerr, s_clr;
  logic       m_work, m_enc;
  logic [7:0] m_data;
  vec_t       vecs [11];
  logic [7:0] pool [10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    s_valid = n_valid; s_ferr = n_ferr; s_cerr = n_cerr; s_clr = n_clr;
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    bus.uart_rxd = v;
    repeat (BIT - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_bit);
  endtask

  // Reference model: effect of one received frame on the host-visible state.
  task automatic model_frame(input logic [7:0] b, input logic good,
                             output int ev, output int ec, output int ecl, output int ef);
    ev = 0; ec = 0; ecl = 0; ef = 0;
    if (!good) begin
      ef = 1;
    end else begin
      ev = 1;
      m_data = b;
      case (b)
        "W", "w": m_work = 1'b1;
        "S", "s": m_work = 1'b0;
        "E", "e": m_enc  = 1'b1;
        "D", "d": m_enc  = 1'b0;
        "R", "r": ecl    = 1;
        default:  ec     = 1;
      endcase
    end
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] b, input logic stop_ok,
                               input int ev, input logic [7:0] ed, input int ec, input int ecl,
                               input int ef, input logic ew, input logic ee);
    snap();
    send_frame(b, stop_ok);
    idle(BIT);
    check({tag, " rx_valid count"}, n_valid - s_valid, ev);
    check({tag, " rx_data"}, int'(bus.rx_data), int'(ed));
    check({tag, " cmd_err count"}, n_cerr - s_cerr, ec);
    check({tag, " clr count"}, n_clr - s_clr, ecl);
    check({tag, " frame_err count"}, n_ferr - s_ferr, ef);
    check({tag, " work"}, int'(bus.work), int'(ew));
    check({tag, " enc"}, int'(bus.enc), int'(ee));
  endtask

  initial begin
    int ev, ec, ecl, ef, d;
    logic [7:0] b;
    logic good;

    //           byte   stop  ev  data   ec ecl ef work  enc
    vecs[0]  = '{8'h57, 1'b1, 1, 8'h57, 0, 0, 0, 1'b1, 1'b1};  // W
    vecs[1]  = '{8'h41, 1'b1, 1, 8'h41, 1, 0, 0, 1'b1, 1'b1};  // A -> cmd_err
    vecs[2]  = '{8'h53, 1'b0, 0, 8'h41, 0, 0, 1, 1'b1, 1'b1};  // S, bad stop
    vecs[3]  = '{8'h73, 1'b1, 1, 8'h73, 0, 0, 0, 1'b0, 1'b1};  // s
    vecs[4]  = '{8'h65, 1'b1, 1, 8'h65, 0, 0, 0, 1'b0, 1'b1};  // e, same level
    vecs[5]  = '{8'h44, 1'b1, 1, 8'h44, 0, 0, 0, 1'b0, 1'b0};  // D
    vecs[6]  = '{8'h52, 1'b1, 1, 8'h52, 0, 1, 0, 1'b0, 1'b0};  // R -> clr
    vecs[7]  = '{8'h77, 1'b1, 1, 8'h77, 0, 0, 0, 1'b1, 1'b0};  // w
    vecs[8]  = '{8'hD7, 1'b1, 1, 8'hD7, 1, 0, 0, 1'b1, 1'b0};  // W with bit 7 set
    vecs[9]  = '{8'h45, 1'b1, 1, 8'h45, 0, 0, 0, 1'b1, 1'b1};  // E
    vecs[10] = '{8'h00, 1'b1, 1, 8'h00, 1, 0, 0, 1'b1, 1'b1};  // NUL
    pool = '{"W", "w", "S", "s", "E", "e", "D", "d", "R", "r"};

    // Reset state.
    bus.uart_rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rx_data", int'(bus.rx_data), 0);
    check("reset rx_valid", int'(bus.rx_valid), 0);
    check("reset work", int'(bus.work), 0);
    check("reset enc", int'(bus.enc), 1);
    check("reset clr", int'(bus.clr), 0);
    rst = 1'b0;
    idle(10000);
    check("idle pulses", n_valid + n_ferr + n_cerr + n_clr, 0);
    check("idle work", int'(bus.work), 0);
    check("idle enc", int'(bus.enc), 1);

    // Directed table.
    for (int i = 0; i < 11; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].stop, vecs[i].ev, vecs[i].ed,
                    vecs[i].ec, vecs[i].ecl, vecs[i].ef, vecs[i].ew, vecs[i].ee);

    // Short low glitch on the idle line is ignored.
    snap();
    bus.uart_rxd = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    idle(FRAME + BIT);
    check("glitch activity", (n_valid - s_valid) + (n_ferr - s_ferr) + (n_cerr - s_cerr), 0);
    check("glitch rx_data", int'(bus.rx_data), 0);

    // Back-to-back 'd' then 'r' with no idle gap.
    snap();
    send_frame("d", 1'b1);
    send_frame("r", 1'b1);
    idle(BIT);
    check("b2b rx_valid count", n_valid - s_valid, 2);
    check("b2b clr count", n_clr - s_clr, 1);
    check("b2b errors", (n_cerr - s_cerr) + (n_ferr - s_ferr), 0);
    check("b2b enc", int'(bus.enc), 0);
    check("b2b rx_data", int'(bus.rx_data), 8'h72);

    // Break: line held low for four frame periods.
    snap();
    bus.uart_rxd = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    d = n_ferr - s_ferr;
    check("break rx_valid count", n_valid - s_valid, 0);
    check("break frame_err in 3..5", int'(d >= 3 && d <= 5), 1);
    idle(2 * FRAME);
    run_and_check("after break E", "E", 1'b1, 1, 8'h45, 0, 0, 0, 1'b1, 1'b1);

    // Reset in the middle of a 'W' frame after setting work=1, enc=0.
    run_and_check("pre-reset W", "W", 1'b1, 1, 8'h57, 0, 0, 0, 1'b1, 1'b1);
    run_and_check("pre-reset D", "D", 1'b1, 1, 8'h44, 0, 0, 0, 1'b1, 1'b0);
    b = "W";
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    @(negedge clk);
    bus.uart_rxd = b[4];
    rst = 1'b1;
    #1;
    check("midreset work", int'(bus.work), 0);
    check("midreset enc", int'(bus.enc), 1);
    check("midreset rx_data", int'(bus.rx_data), 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    snap();
    idle(2 * FRAME);
    check("midreset no valid", n_valid - s_valid, 0);
    run_and_check("post-reset E", "E", 1'b1, 1, 8'h45, 0, 0, 0, 1'b0, 1'b1);
    m_work = 1'b0; m_enc = 1'b1; m_data = 8'h45;

`ifdef UART_RX_PARITY_EN
    // Wrong parity is a frame error and leaves enc alone.
    run_and_check("parity D", "D", 1'b1, 1, 8'h44, 0, 0, 0, 1'b0, 1'b0);
    snap();
    b = "E";
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    send_bit(1'b1);
    idle(BIT);
    check("badpar frame_err count", n_ferr - s_ferr, 1);
    check("badpar rx_valid count", n_valid - s_valid, 0);
    check("badpar enc", int'(bus.enc), 0);
    m_enc = 1'b0; m_data = 8'h44;
`endif

    // Random frames against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) b = pool[$urandom_range(0, 9)];
      else b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      model_frame(b, good, ev, ec, ecl, ef);
      run_and_check($sformatf("rand%0d(%02h,%0d)", i, b, good), b, good, ev, m_data,
                    ec, ecl, ef, m_work, m_enc);
    end

    check("pulse exclusivity", n_excl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
